// File: rtl/hex_display_scanner_if.sv
// Scanner port bundle: display value/control inputs and per-digit scan outputs.
// Pure wiring; no latency of its own.
// No backpressure: load is a strobe accepted on any cycle.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  logic                      enable;
  logic [3:0]                digit_val;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      digit_blank;
  logic                      frame_done;

  // Source of the value/controls; consumer of the scan outputs.
  modport master (
    output load, value, blank_lz, enable,
    input  digit_val, digit_sel, digit_blank, frame_done
  );

  // The scanner itself.
  modport slave (
    input  load, value, blank_lz, enable,
    output digit_val, digit_sel, digit_blank, frame_done
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scan driver with frame-aligned, tear-free value updates.
// Outputs registered, one cycle behind scan state; a load shows from the first digit-0 slot after the next wrap.
// No backpressure: load is always accepted, a later load before commit overwrites the pending value.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hex_display_scanner_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         disp;
  logic [VW-1:0]         pend;
  logic                  pflag;

  logic                  pcnt_last;
  logic                  idx_last;
  logic                  wrap;
  logic                  commit;
  logic [VW-1:0]         disp_sh;
  logic                  dark;
  logic [NUM_DIGITS-1:0] sel_on;

  // Scan position decode, commit condition and the current slot's appearance.
  always_comb begin
    pcnt_last = (pcnt == PW'(REFRESH_DIV - 1));
    idx_last  = (idx == IW'(NUM_DIGITS - 1));
    wrap      = bus.enable && pcnt_last && idx_last;
    commit    = !bus.enable || wrap;
    // Nibble idx lands in [3:0]; everything above it is the more significant digits,
    // so a zero result means this digit and all higher ones are zero.
    disp_sh   = disp >> {idx, 2'b00};
    dark      = !bus.enable || (bus.blank_lz && (idx != '0) && (disp_sh == '0));
    sel_on    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
  end

  // Prescaler and digit index; held at digit 0 while scanning is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (!bus.enable) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt_last) begin
      pcnt <= '0;
      idx  <= idx_last ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Pending capture and frame-boundary commit; a load on the commit edge goes straight to disp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp  <= '0;
      pend  <= '0;
      pflag <= 1'b0;
    end else begin
      if (bus.load) pend <= bus.value;
      if (commit) begin
        if (bus.load)  disp <= bus.value;
        else if (pflag) disp <= pend;
        pflag <= 1'b0;
      end else if (bus.load) begin
        pflag <= 1'b1;
      end
    end
  end

  // Registered outputs derived from the pre-edge scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.digit_val   <= 4'h0;
      bus.digit_sel   <= '1;
      bus.digit_blank <= 1'b1;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.digit_val  <= disp_sh[3:0];
      bus.frame_done <= wrap;
      if (dark) begin
        bus.digit_sel   <= '1;
        bus.digit_blank <= 1'b1;
      end else begin
        bus.digit_sel   <= sel_on;
        bus.digit_blank <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Fixed vector table, hand-written corner sequences, then random traffic against a time-based model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hex_display_scanner_if #(.NUM_DIGITS(N)) bus ();

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference model: scan position is derived from the number of cycles since
  // scanning (re)started, not from a prescaler/index pair.
  int unsigned m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;

  typedef struct {
    logic        ld;
    logic [15:0] v;
    logic        bl;
    logic        en;
    int          reps;
    logic [3:0]  ev;
    logic [3:0]  es;
    logic        eb;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
  endtask

  // One clock: apply inputs, predict outputs from pre-edge model, advance model, compare.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic bl, input logic en);
    int         d;
    logic [3:0] ev;
    logic [3:0] es;
    logic       eb;
    logic       ef;
    logic       blank;
    logic [3:0] one;
    bus.load     = ld;
    bus.value    = v;
    bus.blank_lz = bl;
    bus.enable   = en;
    d     = int'((m_t / R) % N);
    ev    = 4'((m_disp >> (4 * d)) & 16'hF);
    blank = bl && (d >= 1) && ((m_disp >> (4 * d)) == 16'h0);
    one   = 4'b0001;
    es    = (!en || blank) ? 4'hF : ~(one << d);
    eb    = (es == 4'hF);
    ef    = en && ((m_t % (N * R)) == (N * R - 1));
    if (ld) m_pend = v;
    if (!en || ef) m_disp = m_pend;
    m_t = en ? m_t + 1 : 0;
    @(posedge clk);
    #1;
    chk("model_digit_val",   {28'h0, bus.digit_val},   {28'h0, ev});
    chk("model_digit_sel",   {28'h0, bus.digit_sel},   {28'h0, es});
    chk("model_digit_blank", {31'h0, bus.digit_blank}, {31'h0, eb});
    chk("model_frame_done",  {31'h0, bus.frame_done},  {31'h0, ef});
    @(negedge clk);
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    logic        seen;
    logic        bl_r;
    logic [15:0] rv;

    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = 16'h0;
    bus.blank_lz = 1'b0;
    bus.enable   = 1'b0;
    model_reset();

    // Scan of 0x1234, then leading-zero blanking of 0x0050/0x0000, then 0x0050 unblanked.
    tbl.push_back('{1'b1, 16'h1234, 1'b0, 1'b0, 1, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h4, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h3, 4'hD, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h2, 4'hB, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 3, 4'h1, 4'h7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1, 4'h1, 4'h7, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h4, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0050, 1'b1, 1'b0, 1, 4'h3, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 4'h0, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 4'h5, 4'hD, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 3, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1, 4'h0, 4'hF, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 1, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 4'h0, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0050, 1'b0, 1'b0, 1, 4'h0, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h0, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h5, 4'hD, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4, 4'h0, 4'hB, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 3, 4'h0, 4'h7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1, 4'h0, 4'h7, 1'b0, 1'b1});

    // Reset state.
    @(negedge clk);
    chk("reset_digit_val",   {28'h0, bus.digit_val},   32'h0);
    chk("reset_digit_sel",   {28'h0, bus.digit_sel},   32'hF);
    chk("reset_digit_blank", {31'h0, bus.digit_blank}, 32'h1);
    chk("reset_frame_done",  {31'h0, bus.frame_done},  32'h0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        cyc(tbl[i].ld, tbl[i].v, tbl[i].bl, tbl[i].en);
        chk($sformatf("tbl%0d_val", i),   {28'h0, bus.digit_val},   {28'h0, tbl[i].ev});
        chk($sformatf("tbl%0d_sel", i),   {28'h0, bus.digit_sel},   {28'h0, tbl[i].es});
        chk($sformatf("tbl%0d_blank", i), {31'h0, bus.digit_blank}, {31'h0, tbl[i].eb});
        chk($sformatf("tbl%0d_fd", i),    {31'h0, bus.frame_done},  {31'h0, tbl[i].ef});
      end
    end

    // Tear-free update: load 0xABCD while digit 1 of 0x1234 is lit.
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("tear_digit1_lit", {28'h0, bus.digit_sel}, 32'hD);
    cyc(1'b1, 16'hABCD, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      if (bus.digit_sel == 4'hB) chk("tear_old_digit2", {28'h0, bus.digit_val}, 32'h2);
      if (bus.frame_done) begin
        seen = 1'b1;
        chk("tear_old_digit3_at_fd", {28'h0, bus.digit_val}, 32'h1);
      end
    end
    chk("tear_fd_seen", {31'h0, seen}, 32'h1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("tear_new_digit0_val", {28'h0, bus.digit_val}, 32'hD);
    chk("tear_new_digit0_sel", {28'h0, bus.digit_sel}, 32'hE);

    // Last load wins within a frame.
    cyc(1'b1, 16'h1111, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'h2222, 1'b0, 1'b1);
    for (int k = 0; k < 2 * N * R; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk("lastload_no_1", {31'h0, (bus.digit_val == 4'h1)}, 32'h0);
    end
    chk("lastload_shows_2", {28'h0, bus.digit_val}, 32'h2);

    // Enable drop mid-frame, then restart at digit 0 with a full slot.
    for (int k = 0; k < 6; k++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("drop_sel_off", {28'h0, bus.digit_sel}, 32'hF);
    chk("drop_blank",   {31'h0, bus.digit_blank}, 32'h1);
    for (int k = 0; k < R; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk("reen_digit0", {28'h0, bus.digit_sel}, 32'hE);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("reen_digit1", {28'h0, bus.digit_sel}, 32'hD);

    // Asynchronous reset mid-scan, with a load pending.
    cyc(1'b1, 16'h9876, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_digit_val",   {28'h0, bus.digit_val},   32'h0);
    chk("areset_digit_sel",   {28'h0, bus.digit_sel},   32'hF);
    chk("areset_digit_blank", {31'h0, bus.digit_blank}, 32'h1);
    chk("areset_frame_done",  {31'h0, bus.frame_done},  32'h0);
    model_reset();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("areset_hold_val", {28'h0, bus.digit_val}, 32'h0);
    chk("areset_hold_sel", {28'h0, bus.digit_sel}, 32'hF);

    // Randomized traffic against the model.
    bl_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ((k % 64) == 0) bl_r = 1'($urandom_range(0, 1));
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
      cyc(($urandom_range(0, 7) == 0), rv, bl_r, ($urandom_range(0, 49) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

endmodule
